// File: rtl/abcd_sweep_sequencer_pkg.sv
// Shared definitions for the ABCD sweep sequencer: FSM state encodings and
// default parameter values.
package abcd_sweep_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_FINISH = 2'd3
   } sweep_state_e;

   localparam int DEFAULT_WIDTH         = 4;
   localparam int DEFAULT_SETTLE_CYCLES = 2;

endpackage

// File: rtl/abcd_sweep_sequencer_settle_timer.sv
// Loadable down-counter that times how long each ABCD code is held.
// expire is high while the count is 1, i.e. in the last settle cycle.
module settle_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_value,
   output logic         expire
);

   logic [W-1:0] count_q;

   // Load has priority over decrement; the count never underflows past zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_value;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - W'(1);
      end
   end

   assign expire = (count_q == W'(1));

endmodule

// File: rtl/abcd_sweep_sequencer.sv
// Self-timed sweep of every ABCD code into an external decoder, collecting
// the sampled F values into a truth-table bitmap plus a count of zeros.
module abcd_sweep_sequencer
   import abcd_sweep_sequencer_pkg::*;
#(
   parameter int WIDTH         = DEFAULT_WIDTH,
   parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  START,
   input  logic                  F,
   output logic [WIDTH-1:0]      ABCD,
   output logic [(2**WIDTH)-1:0] MAP,
   output logic [WIDTH:0]        ZERO_CNT,
   output logic                  BUSY,
   output logic                  DONE
);

   localparam int               NUM_VEC  = 2**WIDTH;
   localparam int               TIMER_W  = $clog2(SETTLE_CYCLES) + 1;
   localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(NUM_VEC - 1);

   sweep_state_e          state_q;
   sweep_state_e          state_d;
   logic [WIDTH-1:0]      idx_q;
   logic [NUM_VEC-1:0]    map_q;
   logic [WIDTH:0]        zero_cnt_q;
   logic                  timer_load;
   logic                  timer_dec;
   logic                  timer_expire;
   logic                  last_idx;

   assign last_idx = (idx_q == LAST_IDX);

   settle_timer #(
      .W (TIMER_W)
   ) u_settle_timer (
      .clk        (CLK),
      .rst        (RST),
      .load       (timer_load),
      .dec        (timer_dec),
      .load_value (TIMER_W'(SETTLE_CYCLES)),
      .expire     (timer_expire)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The timer is reloaded whenever a new code starts being driven.
   always_comb begin
      state_d    = state_q;
      timer_load = 1'b0;
      timer_dec  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               state_d    = ST_SETTLE;
               timer_load = 1'b1;
            end
         end
         ST_SETTLE: begin
            timer_dec = 1'b1;
            if (timer_expire) begin
               state_d = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            if (last_idx) begin
               state_d = ST_FINISH;
            end else begin
               state_d    = ST_SETTLE;
               timer_load = 1'b1;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Results survive in IDLE and are cleared only when a new sweep starts.
   always_ff @(posedge CLK) begin
      if (RST) begin
         idx_q      <= '0;
         map_q      <= '0;
         zero_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (START) begin
                  idx_q      <= '0;
                  map_q      <= '0;
                  zero_cnt_q <= '0;
               end
            end
            ST_SAMPLE: begin
               map_q[idx_q] <= F;
               zero_cnt_q   <= zero_cnt_q + {{WIDTH{1'b0}}, ~F};
               if (!last_idx) begin
                  idx_q <= idx_q + WIDTH'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign ABCD     = idx_q;
   assign MAP      = map_q;
   assign ZERO_CNT = zero_cnt_q;
   assign BUSY     = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
   assign DONE     = (state_q == ST_FINISH);

endmodule

// File: tb/tb_abcd_sweep_sequencer.sv
// Directed bench for abcd_sweep_sequencer: a default instance driven by a
// read_and_write decoder model (or tied F), and a SETTLE_CYCLES=1 instance.
module tb_abcd_sweep_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_a = 1'b0;
   logic        start_b = 1'b0;
   int          f_mode = 0;
   logic        f_a;
   logic        f_b;
   logic [3:0]  abcd_a, abcd_b;
   logic [15:0] map_a, map_b;
   logic [4:0]  zero_cnt_a, zero_cnt_b;
   logic        busy_a, busy_b, done_a, done_b;

   // read_and_write truth table, bit i is F for ABCD == i
   logic [15:0] decoder_table = 16'hD5FD;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // f_mode: 0 = decoder model, 1 = tied high, 2 = tied low
   assign f_a = (f_mode == 0) ? decoder_table[abcd_a] : (f_mode == 1);
   assign f_b = abcd_b[0];

   abcd_sweep_sequencer dut_a (
      .CLK      (clk),
      .RST      (rst),
      .START    (start_a),
      .F        (f_a),
      .ABCD     (abcd_a),
      .MAP      (map_a),
      .ZERO_CNT (zero_cnt_a),
      .BUSY     (busy_a),
      .DONE     (done_a)
   );

   abcd_sweep_sequencer #(
      .WIDTH         (4),
      .SETTLE_CYCLES (1)
   ) dut_b (
      .CLK      (clk),
      .RST      (rst),
      .START    (start_b),
      .F        (f_b),
      .ABCD     (abcd_b),
      .MAP      (map_b),
      .ZERO_CNT (zero_cnt_b),
      .BUSY     (busy_b),
      .DONE     (done_b)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Sweep dut_a starting at edge 0; optionally re-pulse START at cycles 5/20/48
   // or assert reset during rst_cycle. Runs 60 cycles after edge 0.
   task automatic applyStimulus(input bit reissue, input int rst_cycle,
                                output int first_done, output int done_count);
      first_done = -1;
      done_count = 0;
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (done_a) begin
            if (first_done < 0) first_done = c;
            done_count++;
         end
         if (rst_cycle == 0 && c == 1) checkOutput("busy_cycle1", 32'(busy_a), 32'd1);
         if (rst_cycle == 0 && c == 49) checkOutput("busy_at_done", 32'(busy_a), 32'd0);
         if (rst_cycle != 0 && c == rst_cycle + 1) begin
            checkOutput("rst_abcd", 32'(abcd_a), 32'd0);
            checkOutput("rst_map", 32'(map_a), 32'd0);
            checkOutput("rst_zero_cnt", 32'(zero_cnt_a), 32'd0);
            checkOutput("rst_busy", 32'(busy_a), 32'd0);
            checkOutput("rst_done", 32'(done_a), 32'd0);
            rst = 1'b0;
         end
         rst     = (rst_cycle != 0 && c == rst_cycle) ? 1'b1 : rst;
         start_a = reissue && (c == 5 || c == 20 || c == 48);
      end
      start_a = 1'b0;
   endtask

   initial begin
      int first_done;
      int done_count;
      int pulse_idx;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_abcd", 32'(abcd_a), 32'd0);
      checkOutput("reset_map", 32'(map_a), 32'd0);
      checkOutput("reset_zero_cnt", 32'(zero_cnt_a), 32'd0);
      checkOutput("reset_busy", 32'(busy_a), 32'd0);
      checkOutput("reset_done", 32'(done_a), 32'd0);
      rst = 1'b0;

      $display("[TB] decoder sweep");
      f_mode = 0;
      applyStimulus(1'b0, 0, first_done, done_count);
      checkOutput("dec_done_cycle", 32'(first_done), 32'd49);
      checkOutput("dec_done_count", 32'(done_count), 32'd1);
      checkOutput("dec_map", 32'(map_a), 32'hD5FD);
      checkOutput("dec_zero_cnt", 32'(zero_cnt_a), 32'd4);
      checkOutput("dec_abcd_hold", 32'(abcd_a), 32'd15);

      $display("[TB] tied F sweeps");
      f_mode = 1;
      applyStimulus(1'b0, 0, first_done, done_count);
      checkOutput("tie1_map", 32'(map_a), 32'hFFFF);
      checkOutput("tie1_zero_cnt", 32'(zero_cnt_a), 32'd0);
      f_mode = 2;
      applyStimulus(1'b0, 0, first_done, done_count);
      checkOutput("tie0_map", 32'(map_a), 32'h0000);
      checkOutput("tie0_zero_cnt", 32'(zero_cnt_a), 32'd16);

      $display("[TB] settle=1 hold timing");
      @(negedge clk);
      start_b = 1'b1;
      @(posedge clk);
      first_done = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         start_b = 1'b0;
         if (c <= 32) checkOutput($sformatf("hold_abcd_c%0d", c), 32'(abcd_b), 32'((c - 1) / 2));
         if (done_b && first_done < 0) first_done = c;
      end
      checkOutput("s1_done_cycle", 32'(first_done), 32'd33);
      checkOutput("s1_map", 32'(map_b), 32'hAAAA);
      checkOutput("s1_zero_cnt", 32'(zero_cnt_b), 32'd8);

      $display("[TB] START re-issued during sweep");
      f_mode = 0;
      applyStimulus(1'b1, 0, first_done, done_count);
      checkOutput("reissue_done_cycle", 32'(first_done), 32'd49);
      checkOutput("reissue_done_count", 32'(done_count), 32'd1);
      checkOutput("reissue_map", 32'(map_a), 32'hD5FD);

      $display("[TB] reset mid-sweep");
      applyStimulus(1'b0, 20, first_done, done_count);
      checkOutput("midrst_done_count", 32'(done_count), 32'd0);
      applyStimulus(1'b0, 0, first_done, done_count);
      checkOutput("after_rst_done_cycle", 32'(first_done), 32'd49);
      checkOutput("after_rst_map", 32'(map_a), 32'hD5FD);
      checkOutput("after_rst_zero_cnt", 32'(zero_cnt_a), 32'd4);

      $display("[TB] START held high");
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      pulse_idx = 0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (done_a) begin
            checkOutput($sformatf("held_done_cycle_%0d", pulse_idx), 32'(c), 32'(49 + 50 * pulse_idx));
            checkOutput($sformatf("held_map_%0d", pulse_idx), 32'(map_a), 32'hD5FD);
            pulse_idx++;
         end
         if (c == 150) checkOutput("held_pulses_by_150", 32'(pulse_idx), 32'd3);
      end
      start_a = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
